// File: rtl/ahbl_splitter_n_if.sv
// rtl/ahbl_splitter_n_if.sv - AHB-Lite master-side and slave-side bus bundle for ahbl_splitter_n
interface ahbl_splitter_n_if #(
    parameter int N_SLAVES = 4
);
    logic [31:0]             HADDR;
    logic [1:0]              HTRANS;
    logic                    HREADY;
    logic [31:0]             HRDATA;
    logic                    HRESP;
    logic [N_SLAVES-1:0]     S_HSEL;
    logic [32*N_SLAVES-1:0]  S_HRDATA;
    logic [N_SLAVES-1:0]     S_HREADYOUT;
    logic [N_SLAVES-1:0]     S_HRESP;

    // splitter side
    modport slave (
        input  HADDR, HTRANS, S_HRDATA, S_HREADYOUT, S_HRESP,
        output HREADY, HRDATA, HRESP, S_HSEL
    );

    // environment side: bus master plus the slaves
    modport master (
        output HADDR, HTRANS, S_HRDATA, S_HREADYOUT, S_HRESP,
        input  HREADY, HRDATA, HRESP, S_HSEL
    );
endinterface

// File: rtl/ahbl_splitter_n.sv
// rtl/ahbl_splitter_n.sv - N-port AHB-Lite splitter with default ERROR slave; stall watchdog under AHBL_SPLIT_TIMEOUT_EN
module ahbl_splitter_n #(
    parameter int                          N_SLAVES       = 4,
    parameter int                          DEC_BITS       = 4,
    parameter logic [N_SLAVES*DEC_BITS-1:0] S_BASE        = {4'h8, 4'h4, 4'h2, 4'h0},
    parameter int                          TIMEOUT_CYCLES = 255
) (
    input  logic              HCLK,
    input  logic              HRESET,
    ahbl_splitter_n_if.slave  bus,
    output logic              TIMEOUT_IRQ
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [DEC_BITS-1:0]   dec_field;
    logic [N_SLAVES-1:0]   match;
    logic [N_SLAVES-1:0]   hsel;
    logic [N_SLAVES-1:0]   sel_q;
    logic                  def_q;

    logic                  hready_o;
    logic [31:0]           hrdata_o;
    logic                  hresp_o;
    logic                  unmapped_req;
    logic                  wd_hit;

    assign dec_field = bus.HADDR[31:32-DEC_BITS];

    // address decode: compare the top field against every slot
    always_comb begin
        match = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            match[i] = (dec_field == S_BASE[i*DEC_BITS +: DEC_BITS]);
        end
    end

    // keep only the lowest set bit so duplicate bases resolve to the lower index
    assign hsel       = match & (~match + N_SLAVES'(1));
    assign bus.S_HSEL = hsel;

    // an active transfer to nobody is being accepted this cycle
    assign unmapped_req = hready_o & bus.HTRANS[1] & ~(|hsel);

    // data-phase owner, captured only when the bus advances
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_q <= '0;
            def_q <= 1'b0;
        end else if (wd_hit) begin
            sel_q <= '0;
            def_q <= 1'b1;
        end else if (hready_o) begin
            sel_q <= hsel;
            def_q <= bus.HTRANS[1] & ~(|hsel);
        end
    end

    // default-slave state register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // default-slave next state: every ERROR is a two-cycle response
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (unmapped_req || wd_hit) state_d = ST_ERR1;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = unmapped_req ? ST_ERR1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // response mux: default slave overrides, else the registered owner drives the master
    always_comb begin
        hready_o = 1'b1;
        hrdata_o = '0;
        hresp_o  = 1'b0;
        case (state_q)
            ST_ERR1: begin
                hready_o = 1'b0;
                hresp_o  = 1'b1;
            end
            ST_ERR2: begin
                hresp_o  = 1'b1;
            end
            default: begin
                if (!def_q) begin
                    for (int k = 0; k < N_SLAVES; k++) begin
                        if (sel_q[k]) begin
                            hready_o = bus.S_HREADYOUT[k];
                            hrdata_o = bus.S_HRDATA[32*k +: 32];
                            hresp_o  = bus.S_HRESP[k];
                        end
                    end
                end
            end
        endcase
    end

    assign bus.HREADY = hready_o;
    assign bus.HRDATA = hrdata_o;
    assign bus.HRESP  = hresp_o;

`ifdef AHBL_SPLIT_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        stalled;
    logic        irq_q;

    assign stalled = (|sel_q) & ~hready_o;
    assign wd_hit  = stalled && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

    // stall counter: counts wait cycles of a real slave, restarts whenever the bus moves
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wd_cnt <= '0;
        end else if (wd_hit || hready_o) begin
            wd_cnt <= '0;
        end else if (stalled) begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end

    // abort pulse lines up with the first ERROR cycle
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= wd_hit;
        end
    end

    assign TIMEOUT_IRQ = irq_q;
`else
    logic [15:0] unused_timeout;

    assign unused_timeout = 16'(TIMEOUT_CYCLES);
    assign wd_hit         = 1'b0;
    assign TIMEOUT_IRQ    = 1'b0;
`endif

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// tb/tb_ahbl_splitter_n.sv - self-checking bench for ahbl_splitter_n
module tb_ahbl_splitter_n;

    localparam int NS = 4;
`ifdef AHBL_SPLIT_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic HCLK = 1'b0;
    logic HRESET;
    logic irq;

    ahbl_splitter_n_if #(.N_SLAVES(NS)) bus();

    ahbl_splitter_n #(
        .N_SLAVES      (NS),
        .DEC_BITS      (4),
        .S_BASE        (16'h8420),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .bus        (bus),
        .TIMEOUT_IRQ(irq)
    );

    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // slave map: slave i answers top nibble base[i]; first match wins
    function automatic int target(input logic [31:0] a);
        int base [4];
        base = '{0, 2, 4, 8};
        for (int i = 0; i < 4; i++) begin
            if (a[31:28] == 4'(base[i])) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_sel(input logic [31:0] a);
        int t;
        t = target(a);
        if (t < 0) return 4'b0000;
        return 4'(1 << t);
    endfunction

    // model: who owns the data phase and how many ERROR cycles remain
    int   m_owner = -1;
    int   m_err   = 0;
    int   m_stall = 0;
    logic m_irq   = 1'b0;
    bit   m_valid = 1'b0;

    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_data;
    logic        e_abort;

    always_comb begin
        e_rdy  = 1'b1;
        e_resp = 1'b0;
        e_data = 32'h0;
        if (m_err == 2) begin
            e_rdy  = 1'b0;
            e_resp = 1'b1;
        end else if (m_err == 1) begin
            e_resp = 1'b1;
        end else if (m_owner >= 0) begin
            e_rdy  = bus.S_HREADYOUT[m_owner];
            e_data = bus.S_HRDATA[32*m_owner +: 32];
            e_resp = bus.S_HRESP[m_owner];
        end
    end

`ifdef AHBL_SPLIT_TIMEOUT_EN
    assign e_abort = (m_err == 0) && (m_owner >= 0) && !e_rdy && (m_stall + 1 == TO);
`else
    assign e_abort = 1'b0;
`endif

    always @(posedge HCLK) begin
        if (HRESET) begin
            m_owner <= -1;
            m_err   <= 0;
            m_stall <= 0;
            m_irq   <= 1'b0;
            m_valid <= 1'b1;
        end else begin
            m_irq <= 1'b0;
            if (m_err == 2) begin
                m_err <= 1;
            end else if (e_abort) begin
                m_owner <= -1;
                m_err   <= 2;
                m_stall <= 0;
                m_irq   <= 1'b1;
            end else if (e_rdy) begin
                m_stall <= 0;
                if (bus.HTRANS[1] && target(bus.HADDR) < 0) begin
                    m_owner <= -1;
                    m_err   <= 2;
                end else begin
                    m_owner <= target(bus.HADDR);
                    m_err   <= 0;
                end
            end else if (m_owner >= 0) begin
                m_stall <= m_stall + 1;
            end
        end
    end

    always @(negedge HCLK) begin
        if (m_valid) begin
            chk("m_hsel",   32'(bus.S_HSEL), 32'(exp_sel(bus.HADDR)));
            chk("m_hready", 32'(bus.HREADY), 32'(e_rdy));
            chk("m_hresp",  32'(bus.HRESP),  32'(e_resp));
            chk("m_hrdata", bus.HRDATA,      e_data);
            chk("m_irq",    32'(irq),        32'(m_irq));
        end
    end

    task automatic step();
        @(posedge HCLK);
        #2;
    endtask

    task automatic look();
        @(negedge HCLK);
    endtask

    initial begin
        HRESET          = 1'b1;
        bus.HADDR       = 32'h8000_0000;
        bus.HTRANS      = 2'b00;
        bus.S_HREADYOUT = '1;
        bus.S_HRESP     = '0;
        bus.S_HRDATA    = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_AAAA};

        // reset
        step();
        step();
        HRESET = 1'b0;
        look();
        chk("rst_hready", 32'(bus.HREADY), 32'd1);
        chk("rst_hresp",  32'(bus.HRESP),  32'd0);
        chk("rst_hrdata", bus.HRDATA,      32'h0);
        chk("rst_hsel",   32'(bus.S_HSEL), 32'b1000);

        // S1 read with two wait states
        bus.HADDR  = 32'h2000_0010;
        bus.HTRANS = 2'b10;
        look();
        chk("s1_hsel", 32'(bus.S_HSEL), 32'b0010);
        chk("s1_addr_rdy", 32'(bus.HREADY), 32'd1);
        step();
        bus.HTRANS = 2'b00;
        bus.HADDR  = 32'h0;
        bus.S_HREADYOUT[1] = 1'b0;
        look();
        chk("s1_wait1", 32'(bus.HREADY), 32'd0);
        step();
        look();
        chk("s1_wait2", 32'(bus.HREADY), 32'd0);
        step();
        bus.S_HREADYOUT[1]    = 1'b1;
        bus.S_HRDATA[63:32]   = 32'hDEAD_BEEF;
        look();
        chk("s1_done_rdy", 32'(bus.HREADY), 32'd1);
        chk("s1_data",     bus.HRDATA,      32'hDEAD_BEEF);
        chk("s1_resp",     32'(bus.HRESP),  32'd0);
        step();

        // single unmapped NONSEQ
        bus.HADDR  = 32'hC000_0000;
        bus.HTRANS = 2'b10;
        look();
        chk("um_hsel", 32'(bus.S_HSEL), 32'b0000);
        step();
        bus.HTRANS = 2'b00;
        bus.HADDR  = 32'h0;
        look();
        chk("um_c1_rdy",  32'(bus.HREADY), 32'd0);
        chk("um_c1_resp", 32'(bus.HRESP),  32'd1);
        chk("um_c1_data", bus.HRDATA,      32'h0);
        step();
        look();
        chk("um_c2_rdy",  32'(bus.HREADY), 32'd1);
        chk("um_c2_resp", 32'(bus.HRESP),  32'd1);
        step();
        look();
        chk("um_end_resp", 32'(bus.HRESP), 32'd0);

        // back-to-back unmapped pair: four ERROR cycles without an OKAY gap
        bus.HADDR  = 32'hC000_0000;
        bus.HTRANS = 2'b10;
        step();
        bus.HADDR  = 32'hD000_0000;
        bus.HTRANS = 2'b11;
        look();
        chk("b2b_1_rdy", 32'(bus.HREADY), 32'd0);
        chk("b2b_1_resp", 32'(bus.HRESP), 32'd1);
        step();
        look();
        chk("b2b_2_rdy", 32'(bus.HREADY), 32'd1);
        chk("b2b_2_resp", 32'(bus.HRESP), 32'd1);
        step();
        bus.HTRANS = 2'b00;
        bus.HADDR  = 32'h0;
        look();
        chk("b2b_3_rdy", 32'(bus.HREADY), 32'd0);
        chk("b2b_3_resp", 32'(bus.HRESP), 32'd1);
        step();
        look();
        chk("b2b_4_rdy", 32'(bus.HREADY), 32'd1);
        chk("b2b_4_resp", 32'(bus.HRESP), 32'd1);
        step();
        look();
        chk("b2b_end_resp", 32'(bus.HRESP), 32'd0);

        // IDLE and BUSY to an unmapped address stay OKAY, zero wait
        bus.HADDR  = 32'hC000_0000;
        bus.HTRANS = 2'b00;
        step();
        look();
        chk("idle_um_rdy",  32'(bus.HREADY), 32'd1);
        chk("idle_um_resp", 32'(bus.HRESP),  32'd0);
        bus.HTRANS = 2'b01;
        step();
        look();
        chk("busy_um_rdy",  32'(bus.HREADY), 32'd1);
        chk("busy_um_resp", 32'(bus.HRESP),  32'd0);
        bus.HTRANS = 2'b00;
        bus.HADDR  = 32'h0;
        step();

        // slave ERROR passes through from S2
        bus.HADDR  = 32'h4000_0000;
        bus.HTRANS = 2'b10;
        step();
        bus.HTRANS     = 2'b00;
        bus.HADDR      = 32'h0;
        bus.S_HRESP[2] = 1'b1;
        look();
        chk("s2_resp", 32'(bus.HRESP), 32'd1);
        chk("s2_data", bus.HRDATA,     32'h2222_0002);
        step();
        bus.S_HRESP[2] = 1'b0;

        // reset during an S1 wait state, then a PMEM fetch
        bus.HADDR  = 32'h2000_0000;
        bus.HTRANS = 2'b10;
        step();
        bus.HTRANS = 2'b00;
        bus.HADDR  = 32'h0;
        bus.S_HREADYOUT[1] = 1'b0;
        look();
        chk("rw_stall", 32'(bus.HREADY), 32'd0);
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        look();
        chk("rw_rdy",  32'(bus.HREADY), 32'd1);
        chk("rw_data", bus.HRDATA,      32'h0);
        chk("rw_resp", 32'(bus.HRESP),  32'd0);
        bus.HADDR  = 32'h0000_0100;
        bus.HTRANS = 2'b10;
        step();
        bus.HTRANS = 2'b00;
        bus.HADDR  = 32'h0;
        look();
        chk("pm_rdy",  32'(bus.HREADY), 32'd1);
        chk("pm_data", bus.HRDATA,      32'h0000_AAAA);
        chk("pm_resp", 32'(bus.HRESP),  32'd0);
        bus.S_HREADYOUT[1] = 1'b1;
        step();

`ifdef AHBL_SPLIT_TIMEOUT_EN
        // S2 never answers: watchdog aborts after TO stall cycles
        begin
            int stalls;
            stalls = 0;
            bus.HADDR  = 32'h4000_0000;
            bus.HTRANS = 2'b10;
            step();
            bus.HTRANS = 2'b00;
            bus.HADDR  = 32'h0;
            bus.S_HREADYOUT[2] = 1'b0;
            for (int n = 0; n < 40; n++) begin
                look();
                if (bus.HRESP) break;
                if (!bus.HREADY) stalls++;
                step();
            end
            chk("to_stalls", 32'(stalls),      32'd8);
            chk("to_irq",    32'(irq),         32'd1);
            chk("to_e1_rdy", 32'(bus.HREADY),  32'd0);
            step();
            look();
            chk("to_e2_rdy",  32'(bus.HREADY), 32'd1);
            chk("to_e2_resp", 32'(bus.HRESP),  32'd1);
            chk("to_e2_irq",  32'(irq),        32'd0);
            step();
            bus.HADDR  = 32'h0000_0200;
            bus.HTRANS = 2'b10;
            step();
            bus.HTRANS = 2'b00;
            bus.HADDR  = 32'h0;
            look();
            chk("to_s0_rdy",  32'(bus.HREADY), 32'd1);
            chk("to_s0_resp", 32'(bus.HRESP),  32'd0);
            chk("to_s0_data", bus.HRDATA,      32'h0000_AAAA);
            step();
        end
`endif

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
